mc_stream_checker: RTL
======================

MC_STREAM_CHECKER -- requirements
Module: mc_stream_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of lockstep output channels (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, sample width per channel.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, width of all counters.
REQ-004 SHALL have port clock  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begins a check run.
REQ-007 SHALL have port sample_count  in  COUNT_WIDTH  samples per channel to check; sampled at start.
REQ-008 SHALL have port stop_on_error  in  1  halt on first mismatch; sampled at start.
REQ-009 SHALL have port act_data  in  NUM_CH*DATA_WIDTH  DUT FIFO heads, channel 0 in LSBs, first-word-fall-through.
REQ-010 SHALL have port act_empty  in  NUM_CH  per-channel DUT FIFO empty.
REQ-011 SHALL have port act_rd_en  out  1  common pop to all DUT FIFOs.
REQ-012 SHALL have port exp_data  in  NUM_CH*DATA_WIDTH  golden samples, same packing.
REQ-013 SHALL have port exp_valid / exp_ready  in / out  1 each  golden stream handshake.
REQ-014 SHALL have ports busy, done, halted  out  1 each  status.
REQ-015 SHALL have ports error_count, sample_index, cycle_count  out  COUNT_WIDTH each.
REQ-016 SHALL have ports first_err_index  out  COUNT_WIDTH, first_err_mask  out  NUM_CH  first mismatch location.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE, HALT.
REQ-018 IDLE/DONE/HALT + start: latch sample_count and stop_on_error, clear all counters and first_err_*, go RUN; sample_count==0 goes to DONE instead.
REQ-019 start in RUN SHALL be ignored.
REQ-020 fire = RUN & exp_valid & ~|act_empty; act_rd_en = exp_ready = fire, combinational from registered state; no partial pops.
REQ-021 On fire, per-channel lane mismatch SHALL be computed in the same cycle; any mismatch increments error_count (saturating at all-ones).
REQ-022 On first mismatching fire of a run, first_err_index = sample_index and first_err_mask = lane mismatch vector; later mismatches do not update them.
REQ-023 sample_index SHALL increment on each fire; when it reaches the latched count, next state DONE.
REQ-024 Mismatch with stop_on_error=1 SHALL go HALT next cycle, that sample still counted; halt has priority over DONE on the final sample.
REQ-025 cycle_count SHALL increment every cycle in RUN, saturating.
REQ-026 busy = (state==RUN); done = (state==DONE); halted = (state==HALT); registered-state decodes.
REQ-027 Counters SHALL hold their values in DONE/HALT until next accepted start.

Reset
REQ-028 Asserted reset SHALL force IDLE, all counters and first_err_* to 0, act_rd_en=exp_ready=busy=done=halted=0 immediately, including mid-run.
REQ-029 Deassertion SHALL be synchronised internally; first start honoured no earlier than second rising edge after deassertion.

Structure
REQ-030 Package mc_checker_pkg SHALL hold state enum, default NUM_CH/DATA_WIDTH/COUNT_WIDTH constants, max NUM_CH.
REQ-031 Sub-module lane_compare (one DATA_WIDTH equality per channel, generate-instantiated) SHALL produce the mismatch vector.
REQ-032 Implementation SHALL be synthesizable, single clock domain.

Verification
REQ-033 NUM_CH=2, count=4, all matching, FIFOs always non-empty -> 4 consecutive pops, done, error_count=0, cycle_count=4.
REQ-034 count=8, ch1 of sample 3 corrupted, stop_on_error=0 -> done, error_count=1, first_err_index=3, first_err_mask=2'b10.
REQ-035 Same stimulus, stop_on_error=1 -> halted after sample 3, sample_index=4, no further act_rd_en.
REQ-036 ch0 empty alternate cycles, exp_valid constant, count=4 -> never pops with any empty, cycle_count=8, errors 0.
REQ-037 Reset asserted after 2 of 5 samples -> outputs 0 same cycle, IDLE; new start with count=3 completes with fresh counters.
REQ-038 count=0 start -> done next cycle, no pops; start during RUN -> ignored, counters undisturbed.

Source files
------------

// File: rtl/mc_checker_pkg.sv
// Shared definitions for the multi-channel stream checker:
// FSM state encoding, default geometry and the channel-count ceiling.
package mc_checker_pkg;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_COUNT_WIDTH = 32;
    localparam int MAX_NUM_CH      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_HALT
    } state_t;

endpackage

// File: rtl/lane_compare.sv
// Single-lane equality check between an actual and a golden sample.
// Ports: act_lane, exp_lane (DATA_WIDTH) in; mismatch (1) out.
module lane_compare
    import mc_checker_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] act_lane,
    input  logic [DATA_WIDTH-1:0] exp_lane,
    output logic                  mismatch
);

    assign mismatch = (act_lane != exp_lane);

endmodule

// File: rtl/mc_stream_checker.sv
// Lockstep multi-channel stream checker: pops all DUT FIFOs together against a
// golden stream, counts mismatches, records the first one, optionally halts.
// Ports: clock, reset (async active-low); start/sample_count/stop_on_error run
// control; act_data/act_empty/act_rd_en DUT FIFOs; exp_data/exp_valid/
// exp_ready golden stream; busy/done/halted status; error_count,
// sample_index, cycle_count, first_err_index, first_err_mask results.
module mc_stream_checker
    import mc_checker_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [COUNT_WIDTH-1:0]       sample_count,
    input  logic                         stop_on_error,
    input  logic [NUM_CH*DATA_WIDTH-1:0] act_data,
    input  logic [NUM_CH-1:0]            act_empty,
    output logic                         act_rd_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] exp_data,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         halted,
    output logic [COUNT_WIDTH-1:0]       error_count,
    output logic [COUNT_WIDTH-1:0]       sample_index,
    output logic [COUNT_WIDTH-1:0]       cycle_count,
    output logic [COUNT_WIDTH-1:0]       first_err_index,
    output logic [NUM_CH-1:0]            first_err_mask
);

    localparam logic [COUNT_WIDTH-1:0] ALL_ONES = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] ONE      = COUNT_WIDTH'(1);

    if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
        $error("NUM_CH out of range");
    end

    // Assertion reaches every register at once; release is retimed to
    // the clock so no flop sees reset removal near an edge.
    logic [1:0] sync;
    logic       rst_int;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    assign rst_int = sync[1];

    state_t                   state;
    state_t                   state_next;
    logic [NUM_CH-1:0]        mismatch;
    logic                     any_mis;
    logic                     fire;
    logic                     accept;
    logic                     last_sample;
    logic [COUNT_WIDTH-1:0]   count_lat;
    logic                     stop_lat;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        lane_compare #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cmp (
            .act_lane (act_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .exp_lane (exp_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .mismatch (mismatch[c])
        );
    end

    assign any_mis     = |mismatch;
    // All lanes pop together or not at all.
    assign fire        = (state == ST_RUN) && exp_valid && !(|act_empty);
    assign act_rd_en   = fire;
    assign exp_ready   = fire;
    assign accept      = (state != ST_RUN) && start;
    assign last_sample = (sample_index + ONE) == count_lat;

    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);
    assign halted = (state == ST_HALT);

    always_ff @(posedge clock or negedge rst_int) begin
        if (!rst_int) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (fire) begin
                    // A halting mismatch wins over completion.
                    if (any_mis && stop_lat) begin
                        state_next = ST_HALT;
                    end else if (last_sample) begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_next = (sample_count == '0) ? ST_DONE : ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_int) begin
        if (!rst_int) begin
            count_lat       <= '0;
            stop_lat        <= 1'b0;
            error_count     <= '0;
            sample_index    <= '0;
            cycle_count     <= '0;
            first_err_index <= '0;
            first_err_mask  <= '0;
        end else if (accept) begin
            count_lat       <= sample_count;
            stop_lat        <= stop_on_error;
            error_count     <= '0;
            sample_index    <= '0;
            cycle_count     <= '0;
            first_err_index <= '0;
            first_err_mask  <= '0;
        end else if (state == ST_RUN) begin
            if (cycle_count != ALL_ONES) begin
                cycle_count <= cycle_count + ONE;
            end
            if (fire) begin
                sample_index <= sample_index + ONE;
                if (any_mis) begin
                    if (error_count != ALL_ONES) begin
                        error_count <= error_count + ONE;
                    end
                    // A zero error count means this is the first mismatch.
                    if (error_count == '0) begin
                        first_err_index <= sample_index;
                        first_err_mask  <= mismatch;
                    end
                end
            end
        end
    end

endmodule
